booth_controller: RTL and testbench
===================================

BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  reset, asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 q0  input  1  LSB of multiplier (Q) register.
REQ-006 qm1  input  1  Q-1 Booth bit.
REQ-007 ld_m  output  1  load multiplicand register.
REQ-008 ld_q  output  1  load multiplier register.
REQ-009 clr_a  output  1  synchronous clear of accumulator (A) register.
REQ-010 clr_qm1  output  1  synchronous clear of Q-1 flop.
REQ-011 ld_a  output  1  load A with adder/subtractor result.
REQ-012 addsub  output  1  1 = A-M, 0 = A+M; meaningful only while ld_a=1.
REQ-013 sft_en  output  1  arithmetic right shift of A, Q and Q-1 together.
REQ-014 count  output  $clog2(WIDTH+1)  iterations remaining.
REQ-015 busy  output  1  high in INIT, EVAL, ARITH and SHIFT.
REQ-016 done  output  1  single-cycle completion pulse.

Function
REQ-017 States: IDLE, INIT, EVAL, ARITH, SHIFT, DONE; all outputs are registered or decoded from the current state only, with no combinational path from inputs to outputs.
REQ-018 IDLE: all control outputs 0; start=1 -> INIT; start=0 -> stay in IDLE.
REQ-019 INIT, one cycle: ld_m=ld_q=clr_a=clr_qm1=1; count loads WIDTH; -> EVAL.
REQ-020 EVAL, one cycle: decode {q0,qm1}.
- 2'b10 -> ARITH with addsub=1.
- 2'b01 -> ARITH with addsub=0.
- 2'b00 or 2'b11 -> SHIFT.
- No control output is active in EVAL.
REQ-021 ARITH, one cycle: ld_a=1 and addsub holds the value latched in EVAL; -> SHIFT.
REQ-022 SHIFT, one cycle: sft_en=1; count decrements by 1 on exit.
- -> DONE if count was 1 on entry.
- -> EVAL otherwise.
REQ-023 DONE, one cycle: done=1 and busy=0; -> IDLE unconditionally.
REQ-024 ld_a and sft_en are never high in the same cycle; each iteration performs at most one add or subtract and exactly one shift.
REQ-025 Latency: done is high in cycle 2*WIDTH+2+N after the clk edge that samples start, where N is the number of ARITH visits (0..WIDTH).
REQ-026 start is ignored outside IDLE and in DONE; a new start may be sampled in the IDLE cycle that follows DONE.
REQ-027 count never wraps: it holds WIDTH from INIT until the first SHIFT, reaches 0 only on the final SHIFT, and stays 0 through DONE and IDLE until the next INIT.
REQ-028 q0 and qm1 are sampled only in EVAL; their values in other states have no effect.

Reset
REQ-029 clr=1 asynchronously forces state IDLE, count=0, and all control outputs plus busy and done to 0, including when asserted mid-operation.
REQ-030 After clr deasserts, the block waits in IDLE for start; no partial operation resumes.

Verification
REQ-031 The bench models the A/Q/Q-1 datapath, or instantiates the team's shift registers, so that q0 and qm1 follow sft_en, and checks the final {A,Q} product.
REQ-032 WIDTH=32, Q=0, M=32'h7 -> no ld_a pulses, done at cycle 66, product 0.
REQ-033 WIDTH=32, Q=32'h1, M=32'h5 -> ld_a with addsub=1 in iteration 1 and addsub=0 in iteration 2, done at cycle 68, product 5.
REQ-034 WIDTH=32, Q=32'hFFFF_FFFF (-1), M=32'h3 -> exactly one ld_a (subtract), done at cycle 67, product 64'hFFFF_FFFF_FFFF_FFFD.
REQ-035 WIDTH=32, Q=32'h5555_5555 -> ld_a in all 32 iterations, done at cycle 98; start held high throughout causes no restart before DONE.
REQ-036 clr pulsed in cycle 20 of an operation -> same-cycle busy=0, count=0, state IDLE; a following start runs a full, correct multiply.

Source files
------------

// File: rtl/booth_controller.sv
// -----------------------------------------------------------------------------
// booth_controller
//
// Control unit for a radix-2 Booth multiplier. It sequences an external
// datapath made of a multiplicand register (M), an accumulator (A), a
// multiplier shift register (Q) and the Q-1 Booth flop. Each of the WIDTH
// iterations looks at {Q[0], Q-1}. If the pair is 10 it subtracts M from A,
// if it is 01 it adds M to A, and in every case it then shifts
// {A, Q, Q-1} one place to the right arithmetically.
//
// Parameters
//   WIDTH    operand width in bits (2..32)
//
// Ports
//   clk      rising-edge clock for all state
//   clr      asynchronous active-high reset; returns the block to IDLE
//   start    multiply request, sampled only in IDLE
//   q0       LSB of the multiplier register
//   qm1      Q-1 Booth bit
//   ld_m     load multiplicand register
//   ld_q     load multiplier register
//   clr_a    synchronous clear of the accumulator
//   clr_qm1  synchronous clear of the Q-1 flop
//   ld_a     load A with the adder/subtractor result
//   addsub   1 = A-M, 0 = A+M (meaningful only while ld_a is high)
//   sft_en   arithmetic right shift of A, Q and Q-1 together
//   count    iterations remaining
//   busy     high while an operation is in progress (INIT..SHIFT)
//   done     single-cycle completion pulse
// -----------------------------------------------------------------------------
module booth_controller #(
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic                         q0,
  input  logic                         qm1,
  output logic                         ld_m,
  output logic                         ld_q,
  output logic                         clr_a,
  output logic                         clr_qm1,
  output logic                         ld_a,
  output logic                         addsub,
  output logic                         sft_en,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EVAL,
    S_ARITH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            addsub_q, addsub_d;

  // State, iteration counter and the add/subtract choice latched in EVAL.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      addsub_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addsub_q <= addsub_d;
    end
  end

  // Next-state logic. The counter is loaded as INIT is entered, so it shows
  // WIDTH for the whole first iteration. It only moves when SHIFT is exited,
  // which makes it reach zero exactly on the final shift and stay there until
  // the next start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addsub_d = addsub_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          count_d = COUNT_INIT;
        end
      end

      S_INIT: begin
        state_d = S_EVAL;
      end

      // Only state in which q0/qm1 matter. 10 and 01 need an add or subtract
      // before the shift; 00 and 11 go straight to the shift.
      S_EVAL: begin
        if (q0 ^ qm1) begin
          state_d  = S_ARITH;
          addsub_d = q0;
        end else begin
          state_d  = S_SHIFT;
        end
      end

      S_ARITH: begin
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        count_d = count_q - COUNT_ONE;
        if (count_q == COUNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the state register (plus the registered
  // addsub choice). This keeps every input-to-output path broken by a flop,
  // and the asynchronous clear drops every output in the same cycle.
  always_comb begin
    ld_m    = 1'b0;
    ld_q    = 1'b0;
    clr_a   = 1'b0;
    clr_qm1 = 1'b0;
    ld_a    = 1'b0;
    addsub  = 1'b0;
    sft_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
      end
      S_INIT: begin
        ld_m    = 1'b1;
        ld_q    = 1'b1;
        clr_a   = 1'b1;
        clr_qm1 = 1'b1;
        busy    = 1'b1;
      end
      S_EVAL: begin
        busy    = 1'b1;
      end
      S_ARITH: begin
        ld_a    = 1'b1;
        addsub  = addsub_q;
        busy    = 1'b1;
      end
      S_SHIFT: begin
        sft_en  = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_booth_controller.sv
// -----------------------------------------------------------------------------
// tb_booth_controller
//
// Drives booth_controller with a behavioural A/Q/Q-1/M datapath so that q0
// and qm1 follow the controller's own shifts. Each started multiply pushes
// its expected product, latency and add/sub count into a scoreboard. The
// entry is popped and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_booth_controller;

  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic          q0, qm1;
  logic          ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, sft_en, busy, done;
  logic [CW-1:0] count;

  booth_controller #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .q0(q0), .qm1(qm1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .clr_qm1(clr_qm1),
    .ld_a(ld_a), .addsub(addsub), .sft_en(sft_en), .count(count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath controlled by the DUT.
  logic [W-1:0] a_reg = '0, q_reg = '0, m_reg = '0;
  logic         qm1_reg = 1'b0;
  logic [W-1:0] q_in = '0, m_in = '0;

  assign q0  = q_reg[0];
  assign qm1 = qm1_reg;

  always @(posedge clk) begin
    if (ld_m)    m_reg   <= m_in;
    if (ld_q)    q_reg   <= q_in;
    if (clr_a)   a_reg   <= '0;
    if (clr_qm1) qm1_reg <= 1'b0;
    if (ld_a)    a_reg   <= addsub ? (a_reg - m_reg) : (a_reg + m_reg);
    if (sft_en) begin
      a_reg   <= {a_reg[W-1], a_reg[W-1:1]};
      q_reg   <= {a_reg[0], q_reg[W-1:1]};
      qm1_reg <= q_reg[0];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-operation activity log.
  int arith_cnt = 0;
  int iter = 0;
  int first_cnt = -1;
  int log_iter[$];
  int log_sub[$];

  always @(negedge clk) begin
    if (!clr) check("ld_a_sft_en_exclusive", {63'b0, ld_a & sft_en}, 64'd0);
    if (ld_a) begin
      arith_cnt++;
      log_iter.push_back(iter);
      log_sub.push_back(int'(addsub));
    end
    if (sft_en) begin
      if (iter == 0) first_cnt = int'(count);
      iter++;
    end
  end

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          narith;
  } exp_t;

  exp_t sb[$];
  int   c0 = 0;

  function automatic int booth_ops(input logic [W-1:0] q);
    int n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (q[i] != prev) n++;
      prev = q[i];
    end
    return n;
  endfunction

  task automatic start_op(input logic [W-1:0] q, input logic [W-1:0] m,
                          input bit hold, input bit track);
    exp_t e;
    @(negedge clk);
    q_in = q;
    m_in = m;
    arith_cnt = 0;
    iter = 0;
    first_cnt = -1;
    log_iter.delete();
    log_sub.delete();
    if (track) begin
      e.prod   = 64'(longint'($signed(q)) * longint'($signed(m)));
      e.narith = booth_ops(q);
      e.lat    = 2 * W + 2 + e.narith;
      sb.push_back(e);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit   seen = 0;
    int   lat;
    exp_t e;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e   = sb.pop_front();
      lat = cyc - c0 + 1;
      check({tag, "_latency"},     64'(lat),       64'(e.lat));
      check({tag, "_product"},     {a_reg, q_reg}, e.prod);
      check({tag, "_arith_count"}, 64'(arith_cnt), 64'(e.narith));
      check({tag, "_busy_at_done"},  {63'b0, busy}, 64'd0);
      check({tag, "_count_at_done"}, 64'(count),    64'd0);
      check({tag, "_count_first_shift"}, 64'(first_cnt), 64'(W));
    end
  endtask

  initial begin
    // Reset, with start asserted to show it is ignored while clr is high.
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy",  {63'b0, busy},  64'd0);
    check("reset_done",  {63'b0, done},  64'd0);
    check("reset_count", 64'(count),     64'd0);
    check("reset_ctrl",  {57'b0, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, sft_en}, 64'd0);
    start = 1'b0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset_busy", {63'b0, busy}, 64'd0);

    // Q=0: no add/subtract, done at 66, product 0.
    start_op(32'h0, 32'h7, 1'b0, 1'b1);
    wait_done("q0_m7");
    check("q0_m7_lat_const", 64'(cyc - c0 + 1), 64'd66);

    // Q=1, M=5: subtract in iteration 1, add in iteration 2, done at 68.
    start_op(32'h1, 32'h5, 1'b0, 1'b1);
    wait_done("q1_m5");
    check("q1_m5_lat_const", 64'(cyc - c0 + 1), 64'd68);
    check("q1_m5_nlog", 64'(log_sub.size()), 64'd2);
    if (log_sub.size() >= 2) begin
      check("q1_m5_iter_a",   64'(log_iter[0]), 64'd0);
      check("q1_m5_sub_a",    64'(log_sub[0]),  64'd1);
      check("q1_m5_iter_b",   64'(log_iter[1]), 64'd1);
      check("q1_m5_sub_b",    64'(log_sub[1]),  64'd0);
    end

    // Q=-1, M=3: a single subtract, done at 67, product -3.
    start_op(32'hFFFF_FFFF, 32'h3, 1'b0, 1'b1);
    wait_done("qm1_m3");
    check("qm1_m3_lat_const", 64'(cyc - c0 + 1), 64'd67);
    check("qm1_m3_prod_const", {a_reg, q_reg}, 64'hFFFF_FFFF_FFFF_FFFD);
    if (log_sub.size() >= 1) check("qm1_m3_sub", 64'(log_sub[0]), 64'd1);

    // Alternating Q with start held high: 32 add/subtracts, done at 98.
    start_op(32'h5555_5555, 32'h1234_5678, 1'b1, 1'b1);
    wait_done("q5555");
    check("q5555_lat_const", 64'(cyc - c0 + 1), 64'd98);
    repeat (3) @(negedge clk);
    check("q5555_no_restart", {63'b0, busy}, 64'd0);

    // Negative multiplicand.
    start_op(32'h8000_0001, 32'hFFFF_FFF9, 1'b0, 1'b1);
    wait_done("q8001_mneg7");

    // Asynchronous clear in cycle 20 of an operation.
    start_op(32'h5555_5555, 32'h9, 1'b0, 1'b0);
    for (int i = 0; i < 100 && (cyc - c0 + 1) < 20; i++) @(negedge clk);
    check("clr_cycle_reached", 64'(cyc - c0 + 1), 64'd20);
    check("clr_busy_before", {63'b0, busy}, 64'd1);
    #1 clr = 1'b1;
    #1;
    check("clr_busy",  {63'b0, busy},  64'd0);
    check("clr_count", 64'(count),     64'd0);
    check("clr_ctrl",  {56'b0, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, sft_en, done}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_stays_idle", {62'b0, busy, done}, 64'd0);

    // A full multiply after the clear.
    start_op(32'h0000_00A5, 32'hFFFF_FF00, 1'b0, 1'b1);
    wait_done("after_clr");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
